// File: rtl/cpu_reg_file.sv
// ============================================================================
// cpu_reg_file : programmer-visible register file (A/X/Y) with Z/N flag output
// Rev 1.0
// ============================================================================
`default_nettype none

module cpu_reg_file #(
  parameter int                 WIDTH       = 8,
  parameter int                 NUM_REGS    = 3,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  localparam int                SELW        = $clog2(NUM_REGS)
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  input  logic [SELW-1:0]   dst_sel,
  input  logic [SELW-1:0]   src_sel,
  input  logic [WIDTH-1:0]  data_bus_in,
  input  logic [SELW-1:0]   rd_sel,
  output logic [WIDTH-1:0]  data_bus_out,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_valid,
  output logic              op_error
);

  localparam logic [2:0] c_OP_NOP  = 3'd0;
  localparam logic [2:0] c_OP_LOAD = 3'd1;
  localparam logic [2:0] c_OP_XFER = 3'd2;
  localparam logic [2:0] c_OP_INC  = 3'd3;
  localparam logic [2:0] c_OP_DEC  = 3'd4;
  localparam logic [2:0] c_OP_CLR  = 3'd5;
  localparam logic [2:0] c_OP_TEST = 3'd6;
  localparam logic [2:0] c_OP_RSVD = 3'd7;

  logic [WIDTH-1:0] r_regs [NUM_REGS];

  logic [WIDTH-1:0] w_src_val;
  logic [WIDTH-1:0] w_dst_val;
  logic [WIDTH-1:0] w_rd_val;
  logic             w_src_ok;
  logic             w_dst_ok;
  logic             w_uses_src;
  logic             w_uses_dst;
  logic             w_err;
  logic             w_exec;
  logic             w_write;
  logic [WIDTH-1:0] w_result;

  // Selects are matched by equality so unused encodings decode to nothing.
  always_comb begin
    w_src_val = '0;
    w_dst_val = '0;
    w_rd_val  = '0;
    w_src_ok  = 1'b0;
    w_dst_ok  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (src_sel == SELW'(i)) begin
        w_src_ok  = 1'b1;
        w_src_val = r_regs[i];
      end
      if (dst_sel == SELW'(i)) begin
        w_dst_ok  = 1'b1;
        w_dst_val = r_regs[i];
      end
      if (rd_sel == SELW'(i)) begin
        w_rd_val = r_regs[i];
      end
    end
  end

  assign data_bus_out = w_rd_val;

  always_comb begin
    w_uses_src = (op_code == c_OP_XFER) || (op_code == c_OP_TEST);
    w_uses_dst = (op_code == c_OP_LOAD) || (op_code == c_OP_XFER) ||
                 (op_code == c_OP_INC)  || (op_code == c_OP_DEC)  ||
                 (op_code == c_OP_CLR);
    w_err   = op_valid && ((op_code == c_OP_RSVD) ||
                           (w_uses_dst && !w_dst_ok) ||
                           (w_uses_src && !w_src_ok));
    w_exec  = op_valid && !w_err && (op_code != c_OP_NOP);
    w_write = w_exec && (op_code != c_OP_TEST);
    case (op_code)
      c_OP_LOAD: w_result = data_bus_in;
      c_OP_XFER: w_result = w_src_val;
      c_OP_INC:  w_result = w_dst_val + WIDTH'(1);
      c_OP_DEC:  w_result = w_dst_val - WIDTH'(1);
      c_OP_TEST: w_result = w_src_val;
      default:   w_result = '0;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RESET_VALUE;
      end
      flag_z     <= (RESET_VALUE == '0);
      flag_n     <= RESET_VALUE[WIDTH-1];
      flag_valid <= 1'b0;
      op_error   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_write && (dst_sel == SELW'(i))) begin
          r_regs[i] <= w_result;
        end
      end
      if (w_exec) begin
        flag_z <= (w_result == '0);
        flag_n <= w_result[WIDTH-1];
      end
      flag_valid <= w_exec;
      op_error   <= w_err;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_reg_file.sv
// Bench for cpu_reg_file: vector table, hand-written reset/wrap sequences and
// randomized ops against an array-based reference model.
`default_nettype none

module tb_cpu_reg_file;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit, 3-register instance
  logic       v8 = 0;
  logic [2:0] op8 = 0;
  logic [1:0] dst8 = 0, src8 = 0, rd8 = 0;
  logic [7:0] din8 = 0;
  logic [7:0] out8;
  logic       z8, n8, fv8, err8;

  cpu_reg_file u_dut (
    .clk_in(clk), .reset(rst), .op_valid(v8), .op_code(op8),
    .dst_sel(dst8), .src_sel(src8), .data_bus_in(din8), .rd_sel(rd8),
    .data_bus_out(out8), .flag_z(z8), .flag_n(n8),
    .flag_valid(fv8), .op_error(err8)
  );

  // 16-bit, 5-register instance with a non-zero reset value
  logic        v16 = 0;
  logic [2:0]  op16 = 0;
  logic [2:0]  dst16 = 0, src16 = 0, rd16 = 0;
  logic [15:0] din16 = 0;
  logic [15:0] out16;
  logic        z16, n16, fv16, err16;

  cpu_reg_file #(.WIDTH(16), .NUM_REGS(5), .RESET_VALUE(16'h8001)) u_dut16 (
    .clk_in(clk), .reset(rst), .op_valid(v16), .op_code(op16),
    .dst_sel(dst16), .src_sel(src16), .data_bus_in(din16), .rd_sel(rd16),
    .data_bus_out(out16), .flag_z(z16), .flag_n(n16),
    .flag_valid(fv16), .op_error(err16)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       v;
    logic [2:0] op;
    logic [1:0] dst, src;
    logic [7:0] din;
    logic [1:0] rd;
    logic [7:0] e_rd;
    logic       e_z, e_n, e_fv, e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [2:0] op, input logic [1:0] dst,
                     input logic [1:0] src, input logic [7:0] din, input logic [1:0] rd,
                     input logic [7:0] e_rd, input logic e_z, input logic e_n,
                     input logic e_fv, input logic e_err);
    vec_t t;
    t.v = v; t.op = op; t.dst = dst; t.src = src; t.din = din; t.rd = rd;
    t.e_rd = e_rd; t.e_z = e_z; t.e_n = e_n; t.e_fv = e_fv; t.e_err = e_err;
    tbl.push_back(t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    v8 = 0; v16 = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step8(input logic v, input logic [2:0] op, input logic [1:0] dst,
                       input logic [1:0] src, input logic [7:0] din, input logic [1:0] rd);
    @(negedge clk);
    v8 = v; op8 = op; dst8 = dst; src8 = src; din8 = din; rd8 = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic step16(input logic v, input logic [2:0] op, input logic [2:0] dst,
                        input logic [2:0] src, input logic [15:0] din, input logic [2:0] rd);
    @(negedge clk);
    v16 = v; op16 = op; dst16 = dst; src16 = src; din16 = din; rd16 = rd;
    @(posedge clk);
    #1;
  endtask

  // Reference model for the 8-bit instance
  logic [7:0] m_reg [3];
  logic       m_z, m_n;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_reg[i] = 8'h00;
    m_z = 1'b1;
    m_n = 1'b0;
  endtask

  task automatic rand_step();
    logic       v, e_err, e_fv;
    logic [2:0] op;
    logic [1:0] dst, src, rd;
    logic [7:0] din, res;
    v   = ($urandom_range(0, 3) != 0);
    op  = 3'($urandom_range(0, 7));
    dst = 2'($urandom_range(0, 3));
    src = 2'($urandom_range(0, 3));
    rd  = 2'($urandom_range(0, 3));
    din = 8'($urandom);
    @(negedge clk);
    v8 = v; op8 = op; dst8 = dst; src8 = src; din8 = din; rd8 = rd;
    #1;
    chk("rand_read_old", 32'(out8), 32'((rd < 3) ? m_reg[rd] : 8'h00));
    e_err = v && ((op == 7) ||
                  ((op == 1 || op == 3 || op == 4 || op == 5) && dst >= 3) ||
                  (op == 2 && (dst >= 3 || src >= 3)) ||
                  (op == 6 && src >= 3));
    e_fv = v && !e_err && (op != 0);
    if (e_fv) begin
      case (op)
        1: res = din;
        2: res = m_reg[src];
        3: res = 8'((int'(m_reg[dst]) + 1) % 256);
        4: res = 8'((int'(m_reg[dst]) + 255) % 256);
        6: res = m_reg[src];
        default: res = 8'h00;
      endcase
      if (op != 6) m_reg[dst] = res;
      m_z = (res == 0);
      m_n = (res >= 8'h80);
    end
    @(posedge clk);
    #1;
    chk("rand_read_new", 32'(out8), 32'((rd < 3) ? m_reg[rd] : 8'h00));
    chk("rand_z", 32'(z8), 32'(m_z));
    chk("rand_n", 32'(n8), 32'(m_n));
    chk("rand_fv", 32'(fv8), 32'(e_fv));
    chk("rand_err", 32'(err8), 32'(e_err));
  endtask

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd8 = 2'(i);
      #1;
      chk("reset_reg8", 32'(out8), 32'h0);
    end
    rd8 = 2'd3; #1;
    chk("reset_rd_oob8", 32'(out8), 32'h0);
    chk("reset_z8", 32'(z8), 1);
    chk("reset_n8", 32'(n8), 0);
    chk("reset_fv8", 32'(fv8), 0);
    chk("reset_err8", 32'(err8), 0);

    // ---------------- vector table (consecutive cycles) ----------------
    //   v op dst src din   rd  e_rd  z n fv err
    add(1, 1, 0, 0, 8'h80, 0, 8'h80, 0, 1, 1, 0); // LOAD A=80
    add(1, 2, 2, 0, 8'h00, 2, 8'h80, 0, 1, 1, 0); // XFER A->Y
    add(1, 1, 1, 0, 8'hFF, 1, 8'hFF, 0, 1, 1, 0); // LOAD X=FF
    add(1, 3, 1, 0, 8'h00, 1, 8'h00, 1, 0, 1, 0); // INC X wraps
    add(1, 4, 1, 0, 8'h00, 1, 8'hFF, 0, 1, 1, 0); // DEC X wraps
    add(1, 7, 0, 0, 8'h11, 0, 8'h80, 0, 1, 0, 1); // reserved op
    add(1, 1, 3, 0, 8'h55, 2, 8'h80, 0, 1, 0, 1); // LOAD bad dst
    add(1, 2, 0, 3, 8'h00, 0, 8'h80, 0, 1, 0, 1); // XFER bad src
    add(1, 6, 0, 3, 8'h00, 0, 8'h80, 0, 1, 0, 1); // TEST bad src
    add(0, 1, 0, 0, 8'h22, 1, 8'hFF, 0, 1, 0, 0); // idle
    add(1, 1, 0, 0, 8'h01, 0, 8'h01, 0, 0, 1, 0); // LOAD A=01
    add(1, 3, 0, 0, 8'h00, 0, 8'h02, 0, 0, 1, 0); // INC A
    add(1, 3, 0, 0, 8'h00, 0, 8'h03, 0, 0, 1, 0); // INC A
    add(1, 6, 1, 0, 8'h00, 0, 8'h03, 0, 0, 1, 0); // TEST A
    add(1, 0, 1, 0, 8'h00, 1, 8'hFF, 0, 0, 0, 0); // NOP
    add(1, 2, 1, 1, 8'h00, 1, 8'hFF, 0, 1, 1, 0); // XFER X->X
    add(1, 5, 2, 0, 8'h00, 2, 8'h00, 1, 0, 1, 0); // CLR Y
    add(0, 0, 0, 0, 8'h00, 3, 8'h00, 1, 0, 0, 0); // read index 3
    add(1, 3, 1, 0, 8'h00, 1, 8'h00, 1, 0, 1, 0); // INC X
    add(1, 2, 0, 1, 8'h00, 0, 8'h00, 1, 0, 1, 0); // XFER X->A
    add(1, 4, 3, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1); // DEC bad dst
    add(1, 1, 0, 0, 8'h7F, 0, 8'h7F, 0, 0, 1, 0); // LOAD A=7F
    add(1, 6, 3, 2, 8'h00, 0, 8'h7F, 1, 0, 1, 0); // TEST Y, dst ignored
    add(0, 0, 0, 0, 8'h00, 0, 8'h7F, 1, 0, 0, 0); // idle
    foreach (tbl[k]) begin
      step8(tbl[k].v, tbl[k].op, tbl[k].dst, tbl[k].src, tbl[k].din, tbl[k].rd);
      chk($sformatf("vec%0d_rd", k), 32'(out8), 32'(tbl[k].e_rd));
      chk($sformatf("vec%0d_z", k), 32'(z8), 32'(tbl[k].e_z));
      chk($sformatf("vec%0d_n", k), 32'(n8), 32'(tbl[k].e_n));
      chk($sformatf("vec%0d_fv", k), 32'(fv8), 32'(tbl[k].e_fv));
      chk($sformatf("vec%0d_err", k), 32'(err8), 32'(tbl[k].e_err));
    end

    // ---------------- mid-stream reset, 8-bit ----------------
    step8(1, 1, 0, 0, 8'h05, 0);
    step8(1, 3, 0, 0, 8'h00, 0);
    chk("mid8_inc", 32'(out8), 32'h06);
    @(negedge clk);
    v8 = 1; op8 = 3; dst8 = 0; rd8 = 0;
    #2 rst = 1'b1;
    #1;
    chk("mid8_async_reg", 32'(out8), 32'h00);
    chk("mid8_async_fv", 32'(fv8), 0);
    chk("mid8_async_z", 32'(z8), 1);
    @(negedge clk);
    v8 = 0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid8_post_reg", 32'(out8), 32'h00);
    chk("mid8_post_fv", 32'(fv8), 0);
    chk("mid8_post_err", 32'(err8), 0);

    // ---------------- 16-bit, 5-register instance ----------------
    for (int i = 0; i < 5; i++) begin
      rd16 = 3'(i);
      #1;
      chk("reset_reg16", 32'(out16), 32'h8001);
    end
    rd16 = 3'd5; #1;
    chk("rd_oob16_5", 32'(out16), 32'h0);
    rd16 = 3'd7; #1;
    chk("rd_oob16_7", 32'(out16), 32'h0);
    chk("reset_z16", 32'(z16), 0);
    chk("reset_n16", 32'(n16), 1);
    step16(1, 1, 4, 0, 16'hFFFF, 4);
    chk("w16_load", 32'(out16), 32'hFFFF);
    chk("w16_load_fv", 32'(fv16), 1);
    step16(1, 3, 4, 0, 16'h0, 4);
    chk("w16_inc_wrap", 32'(out16), 32'h0000);
    chk("w16_inc_z", 32'(z16), 1);
    chk("w16_inc_n", 32'(n16), 0);
    step16(1, 4, 4, 0, 16'h0, 4);
    chk("w16_dec_wrap", 32'(out16), 32'hFFFF);
    chk("w16_dec_n", 32'(n16), 1);
    step16(1, 2, 0, 4, 16'h0, 0);
    chk("w16_xfer", 32'(out16), 32'hFFFF);
    step16(1, 1, 5, 0, 16'h1234, 0);
    chk("w16_bad_dst_err", 32'(err16), 1);
    chk("w16_bad_dst_fv", 32'(fv16), 0);
    chk("w16_bad_dst_n", 32'(n16), 1);
    step16(1, 6, 0, 7, 16'h0, 4);
    chk("w16_bad_src_err", 32'(err16), 1);
    chk("w16_bad_src_reg", 32'(out16), 32'hFFFF);
    step16(1, 1, 2, 0, 16'h0005, 2);
    step16(1, 3, 2, 0, 16'h0, 2);
    chk("mid16_inc", 32'(out16), 32'h0006);
    @(negedge clk);
    v16 = 1; op16 = 3; dst16 = 2; rd16 = 2;
    #2 rst = 1'b1;
    #1;
    chk("mid16_async_reg", 32'(out16), 32'h8001);
    chk("mid16_async_n", 32'(n16), 1);
    @(negedge clk);
    v16 = 0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid16_post_reg", 32'(out16), 32'h8001);
    chk("mid16_post_fv", 32'(fv16), 0);

    // ---------------- randomized ops vs model ----------------
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) rand_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (total=%0d)", total);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/cpu_reg_file.md
Name: cpu_reg_file

Overview:
- Parametrised programmer-visible register file for the 6502 core; replaces the discrete accumulator, X and Y register instances.
- Holds NUM_REGS registers of WIDTH bits.
- Executes one register operation per cycle: load from bus, transfer, increment, decrement, clear or test.
- Produces registered Z/N flags for the status logic, plus an asynchronous-read bus output.

Parameters:
- WIDTH, 8, bits per register.
- NUM_REGS, 3, number of registers (index 0=A, 1=X, 2=Y in the 6502 build); must be >= 2.
- RESET_VALUE, 0, value loaded into every register on reset.
- SELW, $clog2(NUM_REGS), register-select width (derived localparam, not overridden).

Ports:
- clk_in  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- op_valid  input  1  op_code/dst_sel/src_sel are valid this cycle.
- op_code  input  3  0 NOP, 1 LOAD, 2 XFER, 3 INC, 4 DEC, 5 CLR, 6 TEST, 7 reserved.
- dst_sel  input  SELW  destination register index.
- src_sel  input  SELW  source register index (XFER, TEST).
- data_bus_in  input  WIDTH  operand for LOAD.
- rd_sel  input  SELW  read-port register index.
- data_bus_out  output  WIDTH  combinational read of register rd_sel; 0 if rd_sel >= NUM_REGS.
- flag_z  output  1  registered: last result == 0.
- flag_n  output  1  registered: last result MSB.
- flag_valid  output  1  one-cycle pulse; flags were updated on the previous edge.
- op_error  output  1  one-cycle pulse; the previous op was rejected.

Behaviour:
- Reset (async, active-high):
  - All registers = RESET_VALUE.
  - flag_z = (RESET_VALUE == 0), flag_n = RESET_VALUE[WIDTH-1].
  - flag_valid = 0, op_error = 0.
  - Reset asserted mid-operation aborts the op: no write and no flag pulse after release.
- Op execution: sampled on a rising clk_in edge when op_valid=1. The result is written to reg[dst_sel] on that edge (latency 1).
  - LOAD: result = data_bus_in.
  - XFER: result = reg[src_sel]; src == dst is legal and leaves the value unchanged.
  - INC: result = reg[dst] + 1, modulo 2^WIDTH (FF->00, Z=1).
  - DEC: result = reg[dst] - 1, modulo 2^WIDTH (00->FF, N=1). No carry/overflow output.
  - CLR: result = 0.
  - TEST: result = reg[src_sel] for flag computation only; no register write.
  - NOP: no write, flags hold, no pulse.
- Flags: for every accepted op except NOP, on the same edge:
  - flag_z = (result == 0), flag_n = result[WIDTH-1].
  - flag_valid = 1 for exactly one cycle.
- Errors: on op_code 7, or any used select (dst for LOAD/INC/DEC/CLR; dst and src for XFER; src for TEST) >= NUM_REGS:
  - no write, flags hold, flag_valid = 0, op_error = 1 for one cycle.
- op_valid=0: no state change; flag_valid and op_error return to 0.
- Read-during-write: data_bus_out reflects the old value in the op cycle and the new value after the edge. No bypass.
- Back-to-back ops on consecutive cycles are fully supported. Each op sees results of all prior ops, e.g. INC X then XFER X->A delivers the incremented X.
- Unused select encodings (NUM_REGS not a power of 2) never alias onto valid registers.

Test Plan:
- Reset with RESET_VALUE=0, then read all regs -> data_bus_out=00 for rd_sel 0..2; flag_z=1, flag_n=0, flag_valid=0.
- LOAD A=0x80, then XFER A->Y, read Y -> Y=0x80; after each op flag_n=1, flag_z=0, flag_valid pulses once.
- LOAD X=0xFF, INC X -> X=0x00, flag_z=1. Then DEC X -> X=0xFF, flag_n=1, flag_z=0.
- op_code=7, and separately dst_sel=3 with NUM_REGS=3 -> op_error pulses one cycle; registers and flags unchanged; flag_valid=0.
- Back-to-back LOAD A=0x01, INC A, INC A, TEST A on consecutive cycles -> A=0x03; TEST leaves A=0x03, flag_z=0, flag_n=0; flag_valid high on 4 consecutive cycles.
- Assert reset mid-stream between two INC ops on A=0x05 -> A=RESET_VALUE; no flag_valid pulse after release. Repeat with WIDTH=16, NUM_REGS=5 to check 0xFFFF->0x0000 wrap and index 4 accessible.
